dpll_controller: RTL and testbench
==================================

DPLL_CONTROLLER -- requirements
Module: dpll_controller

Interface
REQ-001 Parameter VAR_NUM, default 8: number of variables; width of the one-hot variable buses.
REQ-002 Parameter LEVEL_WIDTH, default 4: width of decision-level values; SHALL satisfy 2**LEVEL_WIDTH > VAR_NUM.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit, used only under DPLL_TIMEOUT_EN.
REQ-004 Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin or restart a search.
- decision_en  out  1  one-cycle request to the decision engine.
- decision_finish  in  1  decision engine result valid.
- var_in  in  VAR_NUM  decided variable, one-hot; all-zero means no free variable.
- assignment  in  1  value chosen for var_in.
- bcp_en  out  1  one-cycle propagate request.
- bcp_var  out  VAR_NUM  one-hot literal to propagate.
- bcp_value  out  1  value of bcp_var.
- bcp_done  in  1  propagation finished.
- bcp_conflict  in  1  conflict flag, sampled with bcp_done.
- backtrack_en  out  1  one-cycle undo request.
- backtrack_level  out  LEVEL_WIDTH  undo all assignments at levels >= this value.
- backtrack_done  in  1  undo finished.
- level  out  LEVEL_WIDTH  current decision level (stack occupancy).
- sat, unsat, error  out  1 each  terminal status, held until next start or reset.
- timeout  out  1  watchdog expiry; present only under DPLL_TIMEOUT_EN.

Function
REQ-005 FSM states: IDLE, DECIDE, WAIT_DEC, BCP, WAIT_BCP, BACKTRACK, WAIT_BT, SAT, UNSAT.
REQ-006 IDLE: on start, go to DECIDE next cycle; start is ignored in every non-terminal state other than IDLE.
REQ-007 DECIDE: assert decision_en for exactly one cycle, then go to WAIT_DEC.
REQ-008 WAIT_DEC, decision_finish with var_in == 0: go to SAT.
REQ-009 WAIT_DEC, decision_finish with var_in != 0: push {var_in, assignment, flipped=0}, increment level, go to BCP.
REQ-010 A push when level == VAR_NUM SHALL instead set error and go to UNSAT.
REQ-011 BCP: assert bcp_en for one cycle, with bcp_var and bcp_value taken from the stack top, then go to WAIT_BCP.
REQ-012 bcp_var and bcp_value SHALL stay stable until bcp_done.
REQ-013 WAIT_BCP, bcp_done with bcp_conflict=0: go to DECIDE.
REQ-014 WAIT_BCP, bcp_done with bcp_conflict=1: go to BACKTRACK.
REQ-015 BACKTRACK, one action per cycle:
- top flipped=1: pop and decrement level.
- stack empty: go to UNSAT.
- top flipped=0: invert its value, set flipped=1, pulse backtrack_en with backtrack_level=level, go to WAIT_BT.
REQ-016 WAIT_BT: on backtrack_done, go to BCP to propagate the flipped literal.
REQ-017 Each wait state SHALL react only to its own done input; all other handshake inputs are ignored.
REQ-018 In SAT or UNSAT, start SHALL clear the stack, level, sat, unsat and error, then go to DECIDE.
REQ-019 Latency: start to decision_en is 1 cycle; decision_finish to bcp_en is 1 cycle.

Reset
REQ-020 Reset SHALL put the FSM in IDLE and clear the stack and level.
REQ-021 Reset SHALL drive every output to 0, including timeout when present.
REQ-022 Reset asserted in any state SHALL abort the search on the next edge, with no further request pulses.

Configuration
REQ-023 With DPLL_TIMEOUT_EN defined:
- a cycle counter clears on start and counts in non-terminal, non-IDLE states.
- when it reaches TIMEOUT_CYCLES, set timeout and go to UNSAT.
REQ-024 Without DPLL_TIMEOUT_EN: no timeout port, no counter, no timeout behaviour.

Structure
REQ-025 Package dpll_pkg SHALL hold:
- the FSM state enum.
- the stack entry struct (var, value, flipped).
- default parameter constants.
REQ-026 The LIFO SHALL be a sub-module, decision_stack, with push, pop, top-modify, empty and full.

Verification
REQ-027 Engine returns var 8'h01/1, then 8'h02/0, then 8'h00; BCP never conflicts -> sat=1, level=2.
REQ-028 Var 8'h01/1, then conflict on its BCP, then no conflict, then 8'h00 -> backtrack_level=1, bcp_value=0 on the flipped BCP, then sat=1.
REQ-029 Var 8'h01/0, conflict, flip, conflict again -> pop to empty, unsat=1, level=0.
REQ-030 Engine keeps returning new vars past VAR_NUM=8 decisions -> error=1, unsat=1.
REQ-031 Reset during WAIT_BCP at level 3 -> next cycle: IDLE, level=0, all outputs 0, and a late bcp_done is ignored.
REQ-032 With DPLL_TIMEOUT_EN and TIMEOUT_CYCLES=50, decision_finish withheld -> timeout=1 and unsat=1 at cycle 50 after start.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared state encoding, stack entry type and parameter defaults for the DPLL controller.
package dpll_pkg;

    localparam int DPLL_VAR_NUM        = 8;
    localparam int DPLL_LEVEL_WIDTH    = 4;
    localparam int DPLL_TIMEOUT_CYCLES = 1024;
    // Entries hold a variable index rather than a one-hot vector; 8 bits covers up to 256 variables.
    localparam int DPLL_IDX_W          = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_WAIT_DEC,
        ST_BCP,
        ST_WAIT_BCP,
        ST_BACKTRACK,
        ST_WAIT_BT,
        ST_SAT,
        ST_UNSAT
    } dpll_state_e;

    typedef struct packed {
        logic [DPLL_IDX_W-1:0] vidx;
        logic                  value;
        logic                  flipped;
    } dpll_entry_t;

endpackage

// File: rtl/decision_stack.sv
// LIFO of decision entries with push, pop, in-place top modify and clear; count doubles as decision level.
module decision_stack
    import dpll_pkg::*;
#(
    parameter int DEPTH = DPLL_VAR_NUM,
    parameter int CNT_W = DPLL_LEVEL_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  dpll_entry_t      push_entry,
    input  logic             pop,
    input  logic             modify,
    input  dpll_entry_t      mod_entry,
    output dpll_entry_t      top,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dpll_entry_t      mem_q [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [AW-1:0]    top_idx, push_idx;

    assign top_idx  = AW'(count_q - CNT_W'(1));
    assign push_idx = AW'(count_q);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign top      = empty ? '0 : mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (push && !full)
            count_d = count_q + CNT_W'(1);
        else if (pop && !empty)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Storage needs no reset: entries above count are never observed.
    always_ff @(posedge clock) begin
        if (!reset && !clear) begin
            if (push && !full)
                mem_q[push_idx] <= push_entry;
            else if (modify && !empty)
                mem_q[top_idx] <= mod_entry;
        end
    end

endmodule

// File: rtl/dpll_controller.sv
// DPLL search controller sequencing decide / propagate / backtrack handshakes over a decision stack.
// Defining DPLL_TIMEOUT_EN adds a watchdog counter and the timeout output.
module dpll_controller
    import dpll_pkg::*;
#(
    parameter int VAR_NUM        = DPLL_VAR_NUM,
    parameter int LEVEL_WIDTH    = DPLL_LEVEL_WIDTH,
    parameter int TIMEOUT_CYCLES = DPLL_TIMEOUT_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   decision_en,
    input  logic                   decision_finish,
    input  logic [VAR_NUM-1:0]     var_in,
    input  logic                   assignment,
    output logic                   bcp_en,
    output logic [VAR_NUM-1:0]     bcp_var,
    output logic                   bcp_value,
    input  logic                   bcp_done,
    input  logic                   bcp_conflict,
    output logic                   backtrack_en,
    output logic [LEVEL_WIDTH-1:0] backtrack_level,
    input  logic                   backtrack_done,
    output logic [LEVEL_WIDTH-1:0] level,
`ifdef DPLL_TIMEOUT_EN
    output logic                   timeout,
`endif
    output logic                   sat,
    output logic                   unsat,
    output logic                   error
);

    dpll_state_e            state_q;
    logic                   dec_en_q, bcp_en_q, bt_en_q;
    logic [VAR_NUM-1:0]     bcp_var_q;
    logic                   bcp_value_q;
    logic [LEVEL_WIDTH-1:0] bt_level_q;
    logic                   sat_q, unsat_q, error_q;
    logic                   tmo_hit;

    logic                   stk_push, stk_pop, stk_mod, stk_clear;
    logic                   stk_empty, stk_full;
    logic [LEVEL_WIDTH-1:0] stk_count;
    dpll_entry_t            stk_top, push_entry, mod_entry;
    logic [DPLL_IDX_W-1:0]  var_idx;
    logic [VAR_NUM-1:0]     top_onehot;

    always_comb begin
        var_idx = '0;
        for (int i = 0; i < VAR_NUM; i++)
            if (var_in[i]) var_idx = DPLL_IDX_W'(i);
    end

    assign top_onehot = VAR_NUM'(1) << stk_top.vidx;
    assign push_entry = '{vidx: var_idx, value: assignment, flipped: 1'b0};
    assign mod_entry  = '{vidx: stk_top.vidx, value: ~stk_top.value, flipped: 1'b1};

    // Stack operations mirror the FSM branches below so both commit on the same edge.
    always_comb begin
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_mod   = 1'b0;
        stk_clear = 1'b0;
        if (!tmo_hit) begin
            case (state_q)
                ST_WAIT_DEC:  stk_push = decision_finish && (var_in != '0) && !stk_full;
                ST_BACKTRACK: begin
                    stk_pop = !stk_empty && stk_top.flipped;
                    stk_mod = !stk_empty && !stk_top.flipped;
                end
                ST_SAT, ST_UNSAT: stk_clear = start;
                default: ;
            endcase
        end
    end

    decision_stack #(
        .DEPTH (VAR_NUM),
        .CNT_W (LEVEL_WIDTH)
    ) u_stack (
        .clock      (clock),
        .reset      (reset),
        .clear      (stk_clear),
        .push       (stk_push),
        .push_entry (push_entry),
        .pop        (stk_pop),
        .modify     (stk_mod),
        .mod_entry  (mod_entry),
        .top        (stk_top),
        .empty      (stk_empty),
        .full       (stk_full),
        .count      (stk_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dec_en_q    <= 1'b0;
            bcp_en_q    <= 1'b0;
            bt_en_q     <= 1'b0;
            bcp_var_q   <= '0;
            bcp_value_q <= 1'b0;
            bt_level_q  <= '0;
            sat_q       <= 1'b0;
            unsat_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            dec_en_q <= 1'b0;
            bcp_en_q <= 1'b0;
            bt_en_q  <= 1'b0;
            if (tmo_hit) begin
                state_q <= ST_UNSAT;
                unsat_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: if (start) begin
                        state_q  <= ST_DECIDE;
                        dec_en_q <= 1'b1;
                    end
                    ST_DECIDE: state_q <= ST_WAIT_DEC;
                    ST_WAIT_DEC: if (decision_finish) begin
                        if (var_in == '0) begin
                            state_q <= ST_SAT;
                            sat_q   <= 1'b1;
                        end else if (stk_full) begin
                            state_q <= ST_UNSAT;
                            unsat_q <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q     <= ST_BCP;
                            bcp_en_q    <= 1'b1;
                            bcp_var_q   <= var_in;
                            bcp_value_q <= assignment;
                        end
                    end
                    ST_BCP: state_q <= ST_WAIT_BCP;
                    ST_WAIT_BCP: if (bcp_done) begin
                        if (bcp_conflict) begin
                            state_q <= ST_BACKTRACK;
                        end else begin
                            state_q  <= ST_DECIDE;
                            dec_en_q <= 1'b1;
                        end
                    end
                    // Flipped entries pop one per cycle until an unflipped entry can be tried the other way.
                    ST_BACKTRACK: begin
                        if (stk_empty) begin
                            state_q <= ST_UNSAT;
                            unsat_q <= 1'b1;
                        end else if (!stk_top.flipped) begin
                            state_q    <= ST_WAIT_BT;
                            bt_en_q    <= 1'b1;
                            bt_level_q <= stk_count;
                        end
                    end
                    ST_WAIT_BT: if (backtrack_done) begin
                        state_q     <= ST_BCP;
                        bcp_en_q    <= 1'b1;
                        bcp_var_q   <= top_onehot;
                        bcp_value_q <= stk_top.value;
                    end
                    ST_SAT, ST_UNSAT: if (start) begin
                        state_q  <= ST_DECIDE;
                        dec_en_q <= 1'b1;
                        sat_q    <= 1'b0;
                        unsat_q  <= 1'b0;
                        error_q  <= 1'b0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef DPLL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_q;
    logic          tmo_active;

    assign tmo_active = (state_q != ST_IDLE) && (state_q != ST_SAT) && (state_q != ST_UNSAT);
    assign tmo_hit    = tmo_active && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign timeout    = timeout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else if (start && !tmo_active) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else if (tmo_hit) begin
            timeout_q <= 1'b1;
        end else if (tmo_active) begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign decision_en     = dec_en_q;
    assign bcp_en          = bcp_en_q;
    assign bcp_var         = bcp_var_q;
    assign bcp_value       = bcp_value_q;
    assign backtrack_en    = bt_en_q;
    assign backtrack_level = bt_level_q;
    assign level           = stk_count;
    assign sat             = sat_q;
    assign unsat           = unsat_q;
    assign error           = error_q;

endmodule

// File: tb/tb_dpll_controller.sv
// Self-checking bench for dpll_controller: scripted and random engine responses against a queue-based DPLL model.
module tb_dpll_controller;

    localparam int VN = 8;
    localparam int LW = 4;

    localparam logic [4:0] EV_DEC   = 5'b00001;
    localparam logic [4:0] EV_BCP   = 5'b00010;
    localparam logic [4:0] EV_BT    = 5'b00100;
    localparam logic [4:0] EV_SAT   = 5'b01000;
    localparam logic [4:0] EV_UNSAT = 5'b10000;

    logic          clock = 1'b0;
    logic          reset, start, decision_finish, assignment;
    logic          bcp_done, bcp_conflict, backtrack_done;
    logic [VN-1:0] var_in, bcp_var;
    logic          decision_en, bcp_en, bcp_value, backtrack_en, sat, unsat, error;
    logic [LW-1:0] backtrack_level, level;
`ifdef DPLL_TIMEOUT_EN
    logic          timeout;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [VN-1:0] v;
        logic          val;
        bit            fl;
    } ment_t;

    ment_t         stk[$];
    logic [VN-1:0] sv[$];
    logic          sa[$];
    bit            sc[$];

    always #5 clock = ~clock;

    dpll_controller #(
        .VAR_NUM        (VN),
        .LEVEL_WIDTH    (LW),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .decision_en     (decision_en),
        .decision_finish (decision_finish),
        .var_in          (var_in),
        .assignment      (assignment),
        .bcp_en          (bcp_en),
        .bcp_var         (bcp_var),
        .bcp_value       (bcp_value),
        .bcp_done        (bcp_done),
        .bcp_conflict    (bcp_conflict),
        .backtrack_en    (backtrack_en),
        .backtrack_level (backtrack_level),
        .backtrack_done  (backtrack_done),
        .level           (level),
`ifdef DPLL_TIMEOUT_EN
        .timeout         (timeout),
`endif
        .sat             (sat),
        .unsat           (unsat),
        .error           (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        start = 1'b0; decision_finish = 1'b0; var_in = '0; assignment = 1'b0;
        bcp_done = 1'b0; bcp_conflict = 1'b0; backtrack_done = 1'b0;
    endtask

    // Drive noise on every handshake except the one the DUT is currently waiting for (own: 0 dec, 1 bcp, 2 bt, 3 terminal).
    task automatic hold(input int n, input int own);
        for (int i = 0; i < n; i++) begin
            start           = (own != 3) && ($urandom_range(0, 3) == 0);
            decision_finish = (own != 0) && ($urandom_range(0, 2) == 0);
            var_in          = VN'($urandom);
            assignment      = 1'($urandom);
            bcp_done        = (own != 1) && ($urandom_range(0, 2) == 0);
            bcp_conflict    = 1'($urandom);
            backtrack_done  = (own != 2) && ($urandom_range(0, 2) == 0);
            @(negedge clock);
        end
        quiet();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {decision_en, bcp_en, backtrack_en, sat, unsat, error, bcp_var, bcp_value, backtrack_level}, 0);
        chk({tag, "_level"}, level, 0);
`ifdef DPLL_TIMEOUT_EN
        chk({tag, "_timeout"}, timeout, 0);
`endif
    endtask

    task automatic do_reset(input string tag);
        quiet();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_all_zero(tag);
    endtask

    task automatic wait_evt(input string tag, input logic [4:0] exp, output bit ok);
        logic [4:0] m;
        m = '0;
        for (int i = 0; i < 30; i++) begin
            m = {unsat, sat, backtrack_en, bcp_en, decision_en};
            if (m != '0) break;
            hold(1, 3);
        end
        quiet();
        chk({tag, "_event"}, m, exp);
        ok = (m == exp);
    endtask

    // One search from start to a terminal status; stop_lvl > 0 parks the DUT in WAIT_BCP at that level.
    task automatic run_search(input string tag, input bit rnd, input int stop_lvl, input int max_ev);
        bit ok, c, exp_err;
        logic [4:0] exp;
        logic [VN-1:0] v;
        logic a;
        int n;
        stk.delete();
        exp_err = 1'b0;
        quiet();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({tag, "_start_lat"}, decision_en, 1);
        chk({tag, "_start_clr"}, {sat, unsat, error, level}, 0);
        exp = EV_DEC;
        for (int e = 0; e < max_ev; e++) begin
            wait_evt(tag, exp, ok);
            if (!ok) return;
            chk({tag, "_level"}, level, stk.size());
            n = stk.size();
            case (exp)
                EV_DEC: begin
                    hold(1 + $urandom_range(0, 2), 0);
                    if (sv.size() > 0) begin
                        v = sv.pop_front(); a = sa.pop_front();
                    end else if (rnd && $urandom_range(0, 7) != 0) begin
                        v = '0; v[$urandom_range(0, VN - 1)] = 1'b1; a = 1'($urandom);
                    end else begin
                        v = '0; a = 1'b0;
                    end
                    decision_finish = 1'b1; var_in = v; assignment = a;
                    @(negedge clock);
                    quiet();
                    if (v == '0) exp = EV_SAT;
                    else if (n == VN) begin exp = EV_UNSAT; exp_err = 1'b1; end
                    else begin
                        stk.push_back('{v, a, 1'b0});
                        exp = EV_BCP;
                        chk({tag, "_dec_bcp_lat"}, bcp_en, 1);
                    end
                end
                EV_BCP: begin
                    chk({tag, "_bcp_var"}, bcp_var, stk[n-1].v);
                    chk({tag, "_bcp_value"}, bcp_value, stk[n-1].val);
                    if (n == stop_lvl) begin
                        @(negedge clock);
                        return;
                    end
                    hold(1 + $urandom_range(0, 3), 1);
                    chk({tag, "_bcp_stable"}, {bcp_var, bcp_value}, {stk[n-1].v, stk[n-1].val});
                    if (sc.size() > 0) c = sc.pop_front();
                    else c = rnd && ($urandom_range(0, 2) == 0);
                    bcp_done = 1'b1; bcp_conflict = c;
                    @(negedge clock);
                    quiet();
                    if (!c) exp = EV_DEC;
                    else begin
                        while (stk.size() > 0 && stk[stk.size()-1].fl) void'(stk.pop_back());
                        if (stk.size() == 0) exp = EV_UNSAT;
                        else begin
                            stk[stk.size()-1].val = ~stk[stk.size()-1].val;
                            stk[stk.size()-1].fl  = 1'b1;
                            exp = EV_BT;
                        end
                    end
                end
                EV_BT: begin
                    chk({tag, "_bt_level"}, backtrack_level, n);
                    hold($urandom_range(0, 2), 2);
                    backtrack_done = 1'b1;
                    @(negedge clock);
                    quiet();
                    exp = EV_BCP;
                end
                default: begin
                    chk({tag, "_status"}, {sat, unsat, error}, {exp == EV_SAT, exp == EV_UNSAT, exp_err});
                    hold(2, 3);
                    chk({tag, "_status_held"}, {sat, unsat, error}, {exp == EV_SAT, exp == EV_UNSAT, exp_err});
                    return;
                end
            endcase
        end
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk_all_zero("por");

        // Two decisions, no conflicts, then no free variable.
        sv = '{8'h01, 8'h02, 8'h00}; sa = '{1'b1, 1'b0, 1'b0}; sc = '{1'b0, 1'b0};
        run_search("sat2", 1'b0, 0, 40);
        chk("sat2_level", level, 2);

        // Conflict on first decision, flipped literal propagates cleanly.
        sv = '{8'h01, 8'h00}; sa = '{1'b1, 1'b0}; sc = '{1'b1, 1'b0};
        run_search("flip", 1'b0, 0, 40);

        // Both polarities conflict: pop back to empty.
        sv = '{8'h01}; sa = '{1'b0}; sc = '{1'b1, 1'b1};
        run_search("unsat", 1'b0, 0, 40);
        chk("unsat_level", level, 0);

        // More decisions than variables.
        sv = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        sa = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        sc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_search("overflow", 1'b0, 0, 60);

        // Reset while waiting on propagation at level 3; a late bcp_done must be ignored.
        sv = '{8'h04, 8'h10, 8'h80}; sa = '{1'b0, 1'b1, 1'b1}; sc = '{1'b0, 1'b0};
        run_search("rstmid", 1'b0, 3, 40);
        chk("rstmid_pre_level", level, 3);
        do_reset("rstmid");
        bcp_done = 1'b1; bcp_conflict = 1'b0;
        @(negedge clock);
        quiet();
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_late_done", {decision_en, bcp_en, backtrack_en, sat, unsat, level}, 0);
            @(negedge clock);
        end

        for (int r = 0; r < 12; r++) begin
            sv.delete(); sa.delete(); sc.delete();
            run_search($sformatf("rand%0d", r), 1'b1, 0, 400);
        end

`ifdef DPLL_TIMEOUT_EN
        do_reset("tmo");
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (49) @(negedge clock);
        chk("tmo_before", {timeout, unsat}, 0);
        @(negedge clock);
        chk("tmo_at50", {timeout, unsat}, 2'b11);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
